// File: rtl/hub75_row_scanner_if.sv
`default_nettype none
// ============================================================================
// Module   : hub75_row_scanner_if
// Summary  : Frame-memory read port (1-cycle latency, no back-pressure).
// Revision : 1.0 - initial release
// ============================================================================
interface hub75_row_scanner_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 24
);
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_rd_en,
        output mem_addr,
        input  mem_rdata
    );

    modport slave (
        input  mem_rd_en,
        input  mem_addr,
        output mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/hub75_row_scanner.sv
`default_nettype none
// ============================================================================
// Module   : hub75_row_scanner
// Summary  : Scans frame memory row by row, bit plane by bit plane (LSB first),
//            shifting R/G/B onto a HUB75 panel with binary-weighted display.
// Revision : 1.0 - initial release
// ============================================================================
module hub75_row_scanner #(
    parameter int COLS = 64,
    parameter int ROWS = 16,
    parameter int BITS = 8,
    parameter int BASE = 1
) (
    input  wire                      clk,
    input  wire                      rst,
    input  wire                      start,
    output logic                     busy,
    output logic                     frame_done,
    hub75_row_scanner_if.master      mem_if,
    output logic                     hub_r,
    output logic                     hub_g,
    output logic                     hub_b,
    output logic                     hub_clk,
    output logic                     hub_lat,
    output logic                     hub_oe_n,
    output logic [$clog2(ROWS)-1:0]  hub_addr
);

    localparam int c_ADDR_W   = $clog2(ROWS * COLS);
    localparam int c_ROW_W    = $clog2(ROWS);
    localparam int c_COL_W    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int c_PLANE_W  = (BITS > 1) ? $clog2(BITS) : 1;
    localparam int c_DISP_MAX = BASE << (BITS - 1);
    localparam int c_CNT_W    = (c_DISP_MAX > 1) ? $clog2(c_DISP_MAX) : 1;

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_PREFETCH = 3'd1;
    localparam logic [2:0] c_SHIFT_LO = 3'd2;
    localparam logic [2:0] c_SHIFT_HI = 3'd3;
    localparam logic [2:0] c_LATCH    = 3'd4;
    localparam logic [2:0] c_DISPLAY  = 3'd5;
    localparam logic [2:0] c_BLANK    = 3'd6;

    logic [2:0]           r_state;
    logic [c_ROW_W-1:0]   r_row;
    logic [c_PLANE_W-1:0] r_plane;
    logic [c_COL_W-1:0]   r_col;
    logic [c_CNT_W-1:0]   r_cnt;

    logic                 r_busy;
    logic                 r_frame_done;
    logic                 r_mem_rd_en;
    logic [c_ADDR_W-1:0]  r_mem_addr;
    logic                 r_hub_r;
    logic                 r_hub_g;
    logic                 r_hub_b;
    logic                 r_hub_clk;
    logic                 r_hub_lat;
    logic                 r_hub_oe_n;
    logic [c_ROW_W-1:0]   r_hub_addr;

    logic [BITS-1:0]      w_r_ch;
    logic [BITS-1:0]      w_g_ch;
    logic [BITS-1:0]      w_b_ch;
    logic                 w_last_col;
    logic                 w_last_plane;
    logic                 w_last_row;
    logic [c_ADDR_W-1:0]  w_row_base;
    logic [c_ADDR_W-1:0]  w_next_row_base;
    logic [c_ADDR_W-1:0]  w_next_col_addr;
    logic [c_CNT_W-1:0]   w_disp_load;

    assign w_r_ch = mem_if.mem_rdata[BITS-1:0];
    assign w_g_ch = mem_if.mem_rdata[2*BITS-1:BITS];
    assign w_b_ch = mem_if.mem_rdata[3*BITS-1:2*BITS];

    assign w_last_col   = (r_col   == c_COL_W'(COLS - 1));
    assign w_last_plane = (r_plane == c_PLANE_W'(BITS - 1));
    assign w_last_row   = (r_row   == c_ROW_W'(ROWS - 1));

    assign w_row_base      = c_ADDR_W'(r_row) * c_ADDR_W'(COLS);
    assign w_next_row_base = c_ADDR_W'(r_row + c_ROW_W'(1)) * c_ADDR_W'(COLS);
    assign w_next_col_addr = w_row_base + c_ADDR_W'(r_col) + c_ADDR_W'(1);
    assign w_disp_load     = c_CNT_W'((BASE << r_plane) - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_row        <= '0;
            r_plane      <= '0;
            r_col        <= '0;
            r_cnt        <= '0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_mem_rd_en  <= 1'b0;
            r_mem_addr   <= '0;
            r_hub_r      <= 1'b0;
            r_hub_g      <= 1'b0;
            r_hub_b      <= 1'b0;
            r_hub_clk    <= 1'b0;
            r_hub_lat    <= 1'b0;
            r_hub_oe_n   <= 1'b1;
            r_hub_addr   <= '0;
        end else begin
            r_frame_done <= 1'b0;
            r_mem_rd_en  <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_row       <= '0;
                        r_plane     <= '0;
                        r_col       <= '0;
                        r_busy      <= 1'b1;
                        r_mem_rd_en <= 1'b1;
                        r_mem_addr  <= '0;
                        r_state     <= c_PREFETCH;
                    end
                end
                c_PREFETCH: begin
                    r_state <= c_SHIFT_LO;
                end
                c_SHIFT_LO: begin
                    r_hub_r   <= w_r_ch[r_plane];
                    r_hub_g   <= w_g_ch[r_plane];
                    r_hub_b   <= w_b_ch[r_plane];
                    r_hub_clk <= 1'b1;
                    // Next column's read is visible during SHIFT_HI so its
                    // data lands exactly in the following SHIFT_LO.
                    if (!w_last_col) begin
                        r_mem_rd_en <= 1'b1;
                        r_mem_addr  <= w_next_col_addr;
                    end
                    r_state <= c_SHIFT_HI;
                end
                c_SHIFT_HI: begin
                    r_hub_clk <= 1'b0;
                    if (!w_last_col) begin
                        r_col   <= r_col + c_COL_W'(1);
                        r_state <= c_SHIFT_LO;
                    end else begin
                        r_hub_lat <= 1'b1;
                        r_state   <= c_LATCH;
                    end
                end
                c_LATCH: begin
                    r_hub_lat  <= 1'b0;
                    r_hub_oe_n <= 1'b0;
                    r_cnt      <= w_disp_load;
                    r_state    <= c_DISPLAY;
                end
                c_DISPLAY: begin
                    if (r_cnt == '0) begin
                        r_hub_oe_n <= 1'b1;
                        // Row select moves together with blanking, never while lit.
                        if (w_last_plane && !w_last_row) begin
                            r_hub_addr <= r_row + c_ROW_W'(1);
                        end
                        r_state <= c_BLANK;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_W'(1);
                    end
                end
                c_BLANK: begin
                    r_col <= '0;
                    if (!w_last_plane) begin
                        r_plane     <= r_plane + c_PLANE_W'(1);
                        r_mem_rd_en <= 1'b1;
                        r_mem_addr  <= w_row_base;
                        r_state     <= c_PREFETCH;
                    end else if (!w_last_row) begin
                        r_plane     <= '0;
                        r_row       <= r_row + c_ROW_W'(1);
                        r_mem_rd_en <= 1'b1;
                        r_mem_addr  <= w_next_row_base;
                        r_state     <= c_PREFETCH;
                    end else begin
                        r_busy       <= 1'b0;
                        r_frame_done <= 1'b1;
                        r_mem_addr   <= '0;
                        r_hub_r      <= 1'b0;
                        r_hub_g      <= 1'b0;
                        r_hub_b      <= 1'b0;
                        r_hub_addr   <= '0;
                        r_state      <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // Read latency consumes the register stage, so during SHIFT_LO the colour
    // pins come straight from the returning pixel; other states hold the copy.
    assign hub_r = (r_state == c_SHIFT_LO) ? w_r_ch[r_plane] : r_hub_r;
    assign hub_g = (r_state == c_SHIFT_LO) ? w_g_ch[r_plane] : r_hub_g;
    assign hub_b = (r_state == c_SHIFT_LO) ? w_b_ch[r_plane] : r_hub_b;

    assign hub_clk          = r_hub_clk;
    assign hub_lat          = r_hub_lat;
    assign hub_oe_n         = r_hub_oe_n;
    assign hub_addr         = r_hub_addr;
    assign busy             = r_busy;
    assign frame_done       = r_frame_done;
    assign mem_if.mem_rd_en = r_mem_rd_en;
    assign mem_if.mem_addr  = r_mem_addr;

endmodule
`default_nettype wire
